// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding request FSM feeding a 2-entry instruction buffer.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_req_pc;
  logic [1:0]  r_count;
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [63:0] r_buf_pc    [2];
  logic [31:0] r_buf_instr [2];

  logic        w_fault;
  logic        w_req_fire;
  logic        w_push;
  logic        w_pop;
  logic [63:0] w_redirect_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_fault;

  assign w_redirect_pc = redirect_pc;
  assign w_fault       = r_fault;

  always_ff @(posedge clk) begin
    if (reset)               r_fault <= 1'b0;
    else if (redirect_valid) r_fault <= (redirect_pc[1:0] != 2'b00);
  end
`else
  assign w_redirect_pc = redirect_pc & ~64'h3;
  assign w_fault       = 1'b0;
`endif

  assign fetch_fault    = w_fault;
  assign imem_req_valid = (r_state == ST_REQ) && (r_count != 2'd2) && !w_fault;
  assign imem_req_addr  = r_pc;
  assign if_valid       = (r_count != 2'd0);
  assign if_instr       = r_buf_instr[r_rd_ptr];
  assign if_pc          = r_buf_pc[r_rd_ptr];

  // A redirect flushes the buffer, so it also cancels any push or pop in that cycle.
  assign w_req_fire = imem_req_valid && imem_req_ready;
  assign w_push     = (r_state == ST_WAIT) && imem_rsp_valid && !redirect_valid;
  assign w_pop      = if_valid && if_ready && !redirect_valid;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      // An abandoned request still owes a response; wait it out in ST_DROP.
      case (r_state)
        ST_WAIT, ST_DROP: r_state <= imem_rsp_valid ? ST_REQ : ST_DROP;
        default:          r_state <= ST_REQ;
      endcase
    end else begin
      if (redirect_valid) begin
        r_pc     <= w_redirect_pc;
        r_count  <= 2'd0;
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
      end else begin
        if (w_push) begin
          r_pc     <= r_pc + 64'd4;
          r_wr_ptr <= ~r_wr_ptr;
        end
        if (w_pop) r_rd_ptr <= ~r_rd_ptr;
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end

      case (r_state)
        ST_REQ: begin
          if (w_req_fire) r_state <= redirect_valid ? ST_DROP : ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rsp_valid)      r_state <= ST_REQ;
          else if (redirect_valid) r_state <= ST_DROP;
        end
        ST_DROP: begin
          if (imem_rsp_valid) r_state <= ST_REQ;
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

  // NOTE: buffer storage is deliberately not reset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_req_fire) r_req_pc <= r_pc;
    if (w_push) begin
      r_buf_pc[r_wr_ptr]    <= r_req_pc;
      r_buf_instr[r_wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a PC-stream model
// and a behavioural instruction memory with variable response latency.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fetch_fault    (fetch_fault)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Memory environment
  bit          mem_busy = 1'b0;
  logic [63:0] mem_addr = '0;
  int          mem_wait = 0;
  int          lat_lo   = 0;
  int          lat_hi   = 0;

  // Reference model: next PC decode must see, and fault flag
  logic [63:0] exp_pc  = RST_PC;
  bit          m_fault = 1'b0;
  logic [63:0] seen[$];
  int          pop_cyc[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  // Called at a sample point (#1 after posedge) with inputs already driven.
  task automatic cycle();
    logic        req_fire;
    logic        rsp_fire;
    logic        pop;
    logic [63:0] req_addr;
    req_fire = imem_req_valid && imem_req_ready;
    rsp_fire = imem_rsp_valid;
    req_addr = imem_req_addr;

    if (imem_req_valid === 1'b1) check("one_outstanding", 64'(mem_busy), 64'd0);
    check("fetch_fault", 64'(fetch_fault), 64'(m_fault));
    if (m_fault) check("fault_no_req", 64'(imem_req_valid), 64'd0);

    pop = if_valid && if_ready && !redirect_valid && !reset;
    if (pop) begin
      check("if_pc", if_pc, exp_pc);
      check("if_instr", 64'(if_instr), 64'(mem_word(exp_pc)));
      seen.push_back(if_pc);
      pop_cyc.push_back(cyc);
      exp_pc = exp_pc + 64'd4;
    end

    if (reset) begin
      exp_pc  = RST_PC;
      m_fault = 1'b0;
    end else if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      m_fault = (redirect_pc[1:0] != 2'b00);
      exp_pc  = redirect_pc;
`else
      exp_pc  = redirect_pc & ~64'h3;
`endif
    end

    @(posedge clk);
    #1;
    cyc++;

    if (rsp_fire) mem_busy = 1'b0;
    if (req_fire) begin
      mem_busy = 1'b1;
      mem_addr = req_addr;
      mem_wait = $urandom_range(lat_hi, lat_lo);
    end else if (mem_busy && mem_wait > 0) begin
      mem_wait--;
    end
    imem_rsp_valid = mem_busy && (mem_wait == 0);
    imem_rsp_data  = mem_word(mem_addr);
  endtask

  task automatic do_reset();
    int k;
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    cycle();
    cycle();
    k = 0;
    while (mem_busy && k < 20) begin
      cycle();
      k++;
    end
    reset          = 1'b0;
    imem_req_ready = 1'b1;
  endtask

  task automatic run_until_pop(input int bound);
    int start;
    int k;
    start = seen.size();
    k = 0;
    while (seen.size() == start && k < bound) begin
      cycle();
      k++;
    end
    if (seen.size() == start) check("pop_timeout", 64'd0, 64'd1);
  endtask

  task automatic redirect_to(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int c0;
    bit stale;
    logic [63:0] r;

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, latency and 1-per-2-cycle throughput
    lat_lo = 0; lat_hi = 0; if_ready = 1'b1;
    do_reset();
    check("rst_req_valid", 64'(imem_req_valid), 64'd1);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_fault", 64'(fetch_fault), 64'd0);
    seen.delete(); pop_cyc.delete();
    c0 = cyc;
    while (seen.size() < 3 && cyc < c0 + 20) cycle();
    check("seq_count", 64'(seen.size()), 64'd3);
    if (seen.size() == 3) begin
      check("seq_pc0", seen[0], 64'h1000);
      check("seq_pc1", seen[1], 64'h1004);
      check("seq_pc2", seen[2], 64'h1008);
      check("first_latency", 64'(pop_cyc[0] - c0), 64'd2);
      check("throughput01", 64'(pop_cyc[1] - pop_cyc[0]), 64'd2);
      check("throughput12", 64'(pop_cyc[2] - pop_cyc[1]), 64'd2);
    end

    // Backpressure: buffer fills to exactly two, then drains in order
    if_ready = 1'b0;
    do_reset();
    repeat (10) cycle();
    check("full_if_valid", 64'(if_valid), 64'd1);
    check("full_req_low", 64'(imem_req_valid), 64'd0);
    seen.delete();
    if_ready = 1'b1;
    cycle();
    check("drain_still_valid", 64'(if_valid), 64'd1);
    cycle();
    check("drain_count", 64'(seen.size()), 64'd2);
    if (seen.size() == 2) begin
      check("drain_pc0", seen[0], 64'h1000);
      check("drain_pc1", seen[1], 64'h1004);
    end
    check("drain_empty", 64'(if_valid), 64'd0);

    // Redirect in ST_WAIT one cycle before the response
    lat_lo = 1; lat_hi = 1;
    do_reset();
    cycle();
    seen.delete();
    redirect_to(64'h2000);
    check("drop_no_req", 64'(imem_req_valid), 64'd0);
    cycle();
    check("drop_req_valid", 64'(imem_req_valid), 64'd1);
    check("drop_req_addr", imem_req_addr, 64'h2000);
    run_until_pop(20);
    if (seen.size() > 0) check("drop_first_pc", seen[0], 64'h2000);
    stale = 1'b0;
    foreach (seen[i]) if (seen[i][63:4] == 60'h100) stale = 1'b1;
    check("drop_no_stale", 64'(stale), 64'd0);

    // Redirect coincident with the response
    lat_lo = 0; lat_hi = 0;
    do_reset();
    cycle();
    seen.delete();
    redirect_to(64'h2000);
    check("coinc_req_valid", 64'(imem_req_valid), 64'd1);
    check("coinc_req_addr", imem_req_addr, 64'h2000);
    check("coinc_if_valid", 64'(if_valid), 64'd0);
    run_until_pop(20);
    if (seen.size() > 0) check("coinc_first_pc", seen[0], 64'h2000);

    // Misaligned redirect (no handshake in the redirect cycle)
    do_reset();
    imem_req_ready = 1'b0;
    seen.delete();
    redirect_to(64'h2002);
    imem_req_ready = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_fault_set", 64'(fetch_fault), 64'd1);
    check("mis_no_req", 64'(imem_req_valid), 64'd0);
    repeat (5) cycle();
    check("mis_no_entries", 64'(seen.size()), 64'd0);
    redirect_to(64'h3000);
    check("mis_fault_clr", 64'(fetch_fault), 64'd0);
    check("mis_req_addr", imem_req_addr, 64'h3000);
    run_until_pop(20);
    if (seen.size() > 0) check("mis_first_pc", seen[0], 64'h3000);
`else
    check("mis_no_fault", 64'(fetch_fault), 64'd0);
    check("mis_req_valid", 64'(imem_req_valid), 64'd1);
    check("mis_req_addr", imem_req_addr, 64'h2000);
    run_until_pop(20);
    if (seen.size() > 0) check("mis_first_pc", seen[0], 64'h2000);
`endif

    // Reset while waiting; late response arrives after reset
    lat_lo = 1; lat_hi = 1;
    do_reset();
    cycle();
    reset = 1'b1; imem_req_ready = 1'b0;
    cycle();
    reset = 1'b0; imem_req_ready = 1'b1;
    check("rstw_drop_req", 64'(imem_req_valid), 64'd0);
    cycle();
    check("rstw_req_valid", 64'(imem_req_valid), 64'd1);
    check("rstw_req_addr", imem_req_addr, RST_PC);
    seen.delete();
    run_until_pop(20);
    if (seen.size() > 0) check("rstw_first_pc", seen[0], RST_PC);

    // Randomized traffic against the stream model
    lat_lo = 0; lat_hi = 2;
    do_reset();
    seen.delete();
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(99) == 0);
      imem_req_ready = !reset && ($urandom_range(3) != 0);
      if_ready       = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(15) == 0);
      r = {$urandom(), $urandom()};
      if ($urandom_range(7) != 0) r[1:0] = 2'b00;
      if ($urandom_range(15) == 0) r = 64'hFFFF_FFFF_FFFF_FFF8;
      redirect_pc = r;
      cycle();
    end
    check("random_progress", 64'(seen.size() > 50), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 64'h0, PC loaded on reset.
REQ-002 Port: clk  input  1  clock; all state updates on posedge clk.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: redirect_valid  input  1  next-PC unit requests a control-flow redirect this cycle.
REQ-005 Port: redirect_pc  input  64  redirect target (branch target or PC+4 from next-PC logic).
REQ-006 Port: imem_req_valid  output  1  fetch request to instruction memory.
REQ-007 Port: imem_req_ready  input  1  memory accepts request.
REQ-008 Port: imem_req_addr  output  64  fetch byte address.
REQ-009 Port: imem_rsp_valid  input  1  instruction word returned (no backpressure, in order).
REQ-010 Port: imem_rsp_data  input  32  instruction word.
REQ-011 Port: if_valid  output  1  buffer head valid to decode.
REQ-012 Port: if_ready  input  1  decode consumes head.
REQ-013 Port: if_instr  output  32  head instruction.
REQ-014 Port: if_pc  output  64  PC of head instruction.
REQ-015 Port: fetch_fault  output  1  misaligned redirect trap (see Configuration).

Function
REQ-016 State machine SHALL have states ST_REQ, ST_WAIT, ST_DROP; at most one request outstanding.
REQ-017 ST_REQ: imem_req_valid=1, imem_req_addr=pc, only while buffer count<2; on valid&ready latch req_pc=pc and go ST_WAIT.
REQ-018 ST_WAIT: on imem_rsp_valid push {req_pc, imem_rsp_data} into buffer, pc<=pc+4 (64-bit wrap), go ST_REQ.
REQ-019 Instruction buffer SHALL be a 2-entry FIFO; if_valid=(count!=0); pop on if_valid&if_ready; push and pop in the same cycle SHALL be legal at any count.
REQ-020 Buffer full (count==2) SHALL hold imem_req_valid low; empty SHALL hold if_valid low.
REQ-021 Redirect (any state): pc<=redirect_pc, buffer flushed (count<=0), pop that cycle ignored.
REQ-022 Redirect in ST_REQ without request handshake -> ST_REQ; with handshake same cycle -> ST_DROP.
REQ-023 Redirect in ST_WAIT without response -> ST_DROP; with response same cycle -> response discarded, ST_REQ.
REQ-024 ST_DROP: imem_req_valid=0; next imem_rsp_valid discarded, go ST_REQ; a redirect here updates pc only.
REQ-025 Latency: request at cycle N accepted, earliest response N+1, if_valid at N+2; no combinational path imem_rsp_* -> if_*.
REQ-026 Sustained throughput with 1-cycle memory: one instruction per 2 cycles.

Reset
REQ-027 Reset SHALL set pc=RESET_PC, state=ST_REQ, count=0, fetch_fault=0; if_valid=0 and imem_req_valid=1 with addr RESET_PC in the first cycle after reset deasserts.
REQ-028 Reset mid-operation SHALL abandon any outstanding request; the late response (if any) SHALL be discarded via ST_DROP entered on reset when state was ST_WAIT.
REQ-029 Reset SHALL take priority over redirect.

Configuration
REQ-030 Macro FETCH_MISALIGN_TRAP_EN, when defined: redirect with redirect_pc[1:0]!=0 SHALL set fetch_fault=1 (sticky), flush buffer, suppress requests until an aligned redirect or reset clears it.
REQ-031 When undefined: fetch_fault tied 0; redirect_pc[1:0] ignored (pc<=redirect_pc with low 2 bits cleared).

Verification
REQ-032 Reset, RESET_PC=64'h1000, memory ready always, 1-cycle response -> if_pc sequence 0x1000,0x1004,0x1008 with matching data.
REQ-033 if_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req_valid low, then in-order drain 0x1000,0x1004.
REQ-034 Redirect to 0x2000 in ST_WAIT one cycle before response -> that response dropped, next if_pc=0x2000, no 0x100x entry seen.
REQ-035 Redirect coincident with imem_rsp_valid -> response discarded, next request addr 0x2000 issued the following cycle.
REQ-036 With FETCH_MISALIGN_TRAP_EN, redirect to 0x2002 -> fetch_fault=1, no requests; redirect to 0x3000 -> fault clears, fetch from 0x3000; without macro, redirect 0x2002 fetches 0x2000.
REQ-037 Reset asserted in ST_WAIT, response arrives next cycle -> response discarded, first if_pc=RESET_PC.
